// File: rtl/mult8u_seq_pkg.sv
// Shared types and helpers for the 8x8 sequential multiplier controller.
package mult8u_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StEval0,
        StEval1,
        StDone
    } state_e;

    typedef logic [1:0] pidx_t;

    localparam pidx_t LastPidx = 2'd3;

    // Partial index bit that picks the high nibble of each operand.
    localparam int unsigned SelBHiBit = 0;
    localparam int unsigned SelAHiBit = 1;

    localparam logic [3:0] ShiftK0 = 4'd0;
    localparam logic [3:0] ShiftK1 = 4'd4;
    localparam logic [3:0] ShiftK2 = 4'd4;
    localparam logic [3:0] ShiftK3 = 4'd8;

    function automatic logic [3:0] pp_shift(input pidx_t k);
        logic [3:0] sh;
        case (k)
            2'd0:    sh = ShiftK0;
            2'd1:    sh = ShiftK1;
            2'd2:    sh = ShiftK2;
            default: sh = ShiftK3;
        endcase
        return sh;
    endfunction

    function automatic logic [3:0] nib(input logic [7:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

    function automatic logic [15:0] pp_align(input logic [7:0] p, input pidx_t k);
        return {8'h00, p} << pp_shift(k);
    endfunction

endpackage

// File: rtl/mult8u_seq_core.sv
// Reference 4x4 unsigned multiplier core (shift-add array), purely combinational.
module mult8u_seq_core (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] O
);

    always_comb begin
        O = '0;
        for (int i = 0; i < 4; i++) begin
            if (B[i]) begin
                O = O + ({4'b0000, A} << i);
            end
        end
    end

endmodule

// File: rtl/mult8u_seq_ctrl.sv
// Sequencing controller: 8x8 unsigned product built from four 4x4 partials on an external core,
// with optional swapped-operand recheck, bounded retry and a sticky error flag.
module mult8u_seq_ctrl
    import mult8u_seq_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 2,
    parameter bit          DUAL_EVAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic        out_err,
    output logic [3:0]  core_a,
    output logic [3:0]  core_b,
    input  logic [7:0]  core_p,
    output logic        busy,
    output logic [7:0]  fault_cnt
);

    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    pidx_t       k_q, k_d;
    logic [2:0]  retry_q, retry_d;
    logic        err_q, err_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  p0_q, p0_d;
    logic [3:0]  core_a_q, core_a_d;
    logic [3:0]  core_b_q, core_b_d;
    logic [7:0]  fault_cnt_q, fault_cnt_d;
    logic        advance;
    logic [3:0]  opx, opy;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        retry_d     = retry_q;
        err_d       = err_q;
        acc_d       = acc_q;
        p0_d        = p0_q;
        fault_cnt_d = fault_cnt_q;
        advance     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    k_d     = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                    state_d = StEval0;
                end
            end
            StEval0: begin
                p0_d = core_p;
                if (DUAL_EVAL) begin
                    state_d = StEval1;
                end else begin
                    acc_d   = acc_q + pp_align(core_p, k_q);
                    advance = 1'b1;
                end
            end
            StEval1: begin
                if (core_p == p0_q) begin
                    acc_d   = acc_q + pp_align(p0_q, k_q);
                    retry_d = '0;
                    advance = 1'b1;
                end else begin
                    fault_cnt_d = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;
                    if (retry_q < MaxRetry) begin
                        retry_d = retry_q + 3'd1;
                        state_d = StEval0;
                    end else begin
                        // Retries exhausted: keep the first-order result, flag it unverified.
                        err_d   = 1'b1;
                        acc_d   = acc_q + pp_align(p0_q, k_q);
                        retry_d = '0;
                        advance = 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (k_q != LastPidx) begin
                k_d     = k_q + 2'd1;
                state_d = StEval0;
            end else begin
                state_d = StDone;
            end
        end
    end

    // Operands are loaded on state entry so the core sees them for the whole evaluation cycle.
    always_comb begin
        opx      = nib(a_d, k_d[SelAHiBit]);
        opy      = nib(b_d, k_d[SelBHiBit]);
        core_a_d = '0;
        core_b_d = '0;
        case (state_d)
            StEval0: begin
                core_a_d = opx;
                core_b_d = opy;
            end
            StEval1: begin
                core_a_d = opy;
                core_b_d = opx;
            end
            default: begin
                core_a_d = '0;
                core_b_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            p0_q        <= '0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            p0_q        <= p0_d;
            core_a_q    <= core_a_d;
            core_b_q    <= core_b_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign out_p     = out_valid ? acc_q : 16'h0000;
    assign out_err   = out_valid & err_q;
    assign core_a    = core_a_q;
    assign core_b    = core_b_q;
    assign fault_cnt = fault_cnt_q;

endmodule
